// File: rtl/el_pkg.sv
// Shared types and constants for the clocked-to-dual-rail transmitter.
package el_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitAck = 2'd1,
    StRtz     = 2'd2
  } el_state_e;

  // Per-bit rail pair: index 0 is rail-false, index 1 is rail-true.
  localparam logic [1:0]  Spacer = 2'b00;
  localparam int unsigned RailF  = 0;
  localparam int unsigned RailT  = 1;

  localparam string EncTwoPhase  = "TWO_PHASE";
  localparam string EncFourPhase = "FOUR_PHASE";

endpackage

// File: rtl/el_sync.sv
// Multi-flop synchronizer for the asynchronous acknowledge.
module el_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/el_tx.sv
// Clocked source to dual-rail channel: accepts a word and holds it until the
// downstream acknowledge completes the handshake (two- or four-phase).
module el_tx
  import el_pkg::*;
#(
  parameter string       ENC         = EncTwoPhase,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic [2*DATA_W-1:0] out,
  input  logic                ack_i
);

  el_state_e           state_q, state_d;
  logic [2*DATA_W-1:0] out_q, out_d;
  logic [2*DATA_W-1:0] rails;
  logic                ack_s;
  logic                accept;

  el_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_i),
    .q  (ack_s)
  );

  assign in_ready = (state_q == StIdle) && !rst;
  assign accept   = in_valid && in_ready;

  // One-hot rail pattern of the offered word, shared by both encodings.
  always_comb begin
    rails = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      rails[2*i+RailT] = in_data[i];
      rails[2*i+RailF] = ~in_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

  if (ENC == EncFourPhase) begin : g_four_phase
    always_comb begin
      state_d = state_q;
      out_d   = out_q;
      case (state_q)
        StIdle: begin
          if (accept) begin
            out_d   = rails;
            state_d = StWaitAck;
          end
        end
        StWaitAck: begin
          if (ack_s) begin
            out_d   = {DATA_W{Spacer}};
            state_d = StRtz;
          end
        end
        StRtz: begin
          if (!ack_s) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end else begin : g_two_phase
    logic phase_q, phase_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        phase_q <= 1'b0;
      end else begin
        phase_q <= phase_d;
      end
    end

    always_comb begin
      state_d = state_q;
      out_d   = out_q;
      phase_d = phase_q;
      case (state_q)
        StIdle: begin
          // A stray ack edge while idle only re-aligns the stored phase.
          phase_d = ack_s;
          if (accept) begin
            out_d   = out_q ^ rails;
            state_d = StWaitAck;
          end
        end
        StWaitAck: begin
          if (ack_s != phase_q) begin
            phase_d = ack_s;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_el_tx.sv
// Scoreboarded bench for el_tx: one two-phase and one four-phase instance, each
// driven into a behavioural dual-rail receiver that returns the acknowledge.
module tb_el_tx;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEPTH = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [2];
  logic        in_valid [2];
  logic [7:0]  in_data  [2];
  logic        rdy0, rdy1;
  logic [15:0] out0, out1;
  logic        ack0 = 1'b0;
  logic        ack1 = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Expected-token queues: the stimulus side pushes, the receiver side pops.
  logic [7:0] exp_mem [2][DEPTH];
  int         wr [2];
  int         rd0 = 0;
  int         rd1 = 0;

  int  dly_fix  [2];
  bit  hold     [2];
  int  poke_req [2];
  int  poke_seen0 = 0;
  int  poke_seen1 = 0;
  bit  pend0 = 1'b0;
  bit  pend1 = 1'b0;
  int  cnt0 = 0;
  int  cnt1 = 0;
  logic tgt1 = 1'b0;
  logic dph1 = 1'b0;
  logic [15:0] prev0 = '0;
  logic [15:0] prev1 = '0;

  el_tx #(
    .ENC        ("TWO_PHASE"),
    .DATA_W     (8),
    .SYNC_STAGES(SYNC)
  ) dut_two (
    .clk     (clk),
    .rst     (rst[0]),
    .in_valid(in_valid[0]),
    .in_ready(rdy0),
    .in_data (in_data[0]),
    .out     (out0),
    .ack_i   (ack0)
  );

  el_tx #(
    .ENC        ("FOUR_PHASE"),
    .DATA_W     (8),
    .SYNC_STAGES(SYNC)
  ) dut_four (
    .clk     (clk),
    .rst     (rst[1]),
    .in_valid(in_valid[1]),
    .in_ready(rdy1),
    .in_data (in_data[1]),
    .out     (out1),
    .ack_i   (ack1)
  );

  function automatic logic [15:0] rails(input logic [7:0] d);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = d[i];
      r[2*i]   = ~d[i];
    end
    return r;
  endfunction

  function automatic logic rdy(input int m);
    return (m == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic ack_of(input int m);
    return (m == 0) ? ack0 : ack1;
  endfunction

  function automatic int pick_dly(input int m);
    if (dly_fix[m] < 0) return int'($urandom_range(20, 0));
    return dly_fix[m];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Offer a word; returns 1 ns after the accepting edge.
  task automatic send(input int m, input logic [7:0] w, input bit keep);
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (rdy(m)) begin
        in_data[m]  = w;
        in_valid[m] = 1'b1;
        @(posedge clk);
        exp_mem[m][wr[m] % DEPTH] = w;
        wr[m]++;
        #1;
        in_data[m] = 8'($urandom);
        if (!keep) in_valid[m] = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout mode=%0d got=not_ready exp=ready", m);
    end
  endtask

  task automatic wait_ready(input int m);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (rdy(m) === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout mode=%0d got=0 exp=1", m);
    end
  endtask

  task automatic wait_ack(input int m, input logic v);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (ack_of(m) === v) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout mode=%0d got=%0b exp=%0b", m, ack_of(m), v);
    end
  endtask

  // Receivers: decode each new token, pop and compare, then acknowledge.
  always @(negedge clk) begin
    logic [15:0] diff;
    logic [7:0]  w;
    bit          ok;
    int          d;

    if (rst[0]) begin
      ack0 = 1'b0; pend0 = 1'b0; prev0 = '0; rd0 = wr[0]; poke_seen0 = poke_req[0];
    end else begin
      if (poke_seen0 != poke_req[0]) begin
        poke_seen0 = poke_req[0];
        ack0 = ~ack0;
      end
      if (pend0 && !hold[0]) begin
        cnt0--;
        if (cnt0 <= 0) begin ack0 = ~ack0; pend0 = 1'b0; end
      end
      if (out0 !== prev0) begin
        diff = out0 ^ prev0;
        ok = 1'b1;
        w = '0;
        for (int i = 0; i < 8; i++) begin
          case ({diff[2*i+1], diff[2*i]})
            2'b10:   w[i] = 1'b1;
            2'b01:   w[i] = 1'b0;
            default: ok = 1'b0;
          endcase
        end
        prev0 = out0;
        if (rd0 == wr[0]) begin
          checks++; failures++;
          $display("FAIL tp_sb_extra got=%0h exp=no_token", w);
        end else begin
          check("tp_sb_word", 32'({ok, w}), 32'({1'b1, exp_mem[0][rd0 % DEPTH]}));
          rd0++;
        end
        d = pick_dly(0);
        if (d == 0) ack0 = ~ack0;
        else begin pend0 = 1'b1; cnt0 = d; end
      end
    end

    if (rst[1]) begin
      ack1 = 1'b0; pend1 = 1'b0; prev1 = '0; dph1 = 1'b0; rd1 = wr[1];
      poke_seen1 = poke_req[1];
    end else begin
      if (poke_seen1 != poke_req[1]) begin
        poke_seen1 = poke_req[1];
        ack1 = ~ack1;
      end
      if (pend1 && !hold[1]) begin
        cnt1--;
        if (cnt1 <= 0) begin ack1 = tgt1; pend1 = 1'b0; end
      end
      if (out1 !== prev1) begin
        prev1 = out1;
        if (out1 == '0) begin
          check("fp_spacer_after_data", 32'(dph1), 32'd1);
          dph1 = 1'b0;
          tgt1 = 1'b0;
        end else begin
          ok = !dph1;
          w = '0;
          for (int i = 0; i < 8; i++) begin
            case ({out1[2*i+1], out1[2*i]})
              2'b10:   w[i] = 1'b1;
              2'b01:   w[i] = 1'b0;
              default: ok = 1'b0;
            endcase
          end
          if (rd1 == wr[1]) begin
            checks++; failures++;
            $display("FAIL fp_sb_extra got=%0h exp=no_token", w);
          end else begin
            check("fp_sb_word", 32'({ok, w}), 32'({1'b1, exp_mem[1][rd1 % DEPTH]}));
            rd1++;
          end
          dph1 = 1'b1;
          tgt1 = 1'b1;
        end
        d = pick_dly(1);
        if (d == 0) ack1 = tgt1;
        else begin pend1 = 1'b1; cnt1 = d; end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ref0;
    logic [7:0]  w;
    int          base;
    int          bad;
    int          gap;

    for (int m = 0; m < 2; m++) begin
      rst[m] = 1'b1; in_valid[m] = 1'b0; in_data[m] = '0; wr[m] = 0;
      dly_fix[m] = -1; hold[m] = 1'b0; poke_req[m] = 0;
    end

    // Reset values, then ready on the first cycle out of reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_two", 32'(out0), 32'h0);
    check("rst_out_four", 32'(out1), 32'h0);
    check("rst_rdy_two", 32'(rdy0), 32'h0);
    check("rst_rdy_four", 32'(rdy1), 32'h0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    check("rdy_after_rst_two", 32'(rdy0), 32'h1);
    check("rdy_after_rst_four", 32'(rdy1), 32'h1);

    // Two-phase: 0xFF then 0x00.
    dly_fix[0] = 2;
    send(0, 8'hFF, 1'b0);
    check("tp_ff", 32'(out0), 32'hAAAA);
    check("tp_busy", 32'(rdy0), 32'h0);
    wait_ready(0);
    send(0, 8'h00, 1'b0);
    check("tp_00", 32'(out0), 32'hFFFF);
    wait_ready(0);
    ref0 = 16'hFFFF;

    // Withheld ack with sustained valid: one token, stable output.
    hold[0] = 1'b1;
    base = rd0;
    w = 8'($urandom);
    send(0, w, 1'b1);
    ref0 = ref0 ^ rails(w);
    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (rdy0 !== 1'b0 || out0 !== ref0) bad++;
    end
    check("tp_stall_violations", 32'(bad), 32'h0);
    check("tp_stall_out", 32'(out0), 32'(ref0));
    check("tp_one_outstanding", 32'(rd0), 32'(base + 1));
    hold[0] = 1'b0;
    w = 8'($urandom);
    send(0, w, 1'b0);
    ref0 = ref0 ^ rails(w);
    check("tp_after_stall", 32'(out0), 32'(ref0));
    wait_ready(0);

    // Reset while waiting for ack; next token encodes from all-zero rails.
    hold[0] = 1'b1;
    send(0, 8'($urandom), 1'b0);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    #1;
    check("tp_rst_rdy", 32'(rdy0), 32'h0);
    @(posedge clk);
    #1;
    check("tp_rst_out", 32'(out0), 32'h0);
    check("tp_rst_rdy_hold", 32'(rdy0), 32'h0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    hold[0] = 1'b0;
    #1;
    check("tp_rdy_post_rst", 32'(rdy0), 32'h1);
    send(0, 8'h3C, 1'b0);
    check("tp_phase0", 32'(out0), 32'(rails(8'h3C)));
    wait_ready(0);

    // Four-phase 0xA5 with ack three cycles later; timing counted from the
    // first edge that samples each ack transition.
    dly_fix[1] = 3;
    send(1, 8'hA5, 1'b0);
    check("fp_a5", 32'(out1), 32'h9966);
    wait_ack(1, 1'b1);
    check("fp_data_hold", 32'(out1), 32'h9966);
    for (int k = 1; k < int'(SYNC); k++) begin
      @(posedge clk);
      #1;
      check("fp_data_hold", 32'(out1), 32'h9966);
    end
    @(posedge clk);
    #1;
    check("fp_spacer", 32'(out1), 32'h0);
    wait_ack(1, 1'b0);
    check("fp_rtz_busy", 32'(rdy1), 32'h0);
    for (int k = 1; k < int'(SYNC); k++) begin
      @(posedge clk);
      #1;
      check("fp_rtz_busy", 32'(rdy1), 32'h0);
    end
    @(posedge clk);
    #1;
    check("fp_rtz_ready", 32'(rdy1), 32'h1);

    // Four-phase stray ack edges while idle are ignored.
    poke_req[1]++;
    repeat (6) @(posedge clk);
    #1;
    check("fp_idle_ack_out", 32'(out1), 32'h0);
    check("fp_idle_ack_rdy", 32'(rdy1), 32'h1);
    poke_req[1]++;
    repeat (6) @(posedge clk);
    #1;
    check("fp_idle_ack_out2", 32'(out1), 32'h0);
    check("fp_idle_ack_rdy2", 32'(rdy1), 32'h1);

    // Random words, random ack delays, random gaps and back-to-back runs.
    dly_fix[0] = -1;
    dly_fix[1] = -1;
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 1000; n++) begin
        gap = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
        send(m, 8'($urandom), gap == 0);
        repeat (gap) @(posedge clk);
      end
      in_valid[m] = 1'b0;
      wait_ready(m);
      repeat (4) @(posedge clk);
    end

    check("tp_sb_drained", 32'(rd0), 32'(wr[0]));
    check("fp_sb_drained", 32'(rd1), 32'(wr[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
